uart_baud_frac_gen: RTL
=======================

# uart_baud_frac_gen

Parametrised UART baud timing generator for the UART sub-system.
- Builds an oversampling tick from ACLK with an integer-plus-fractional divisor, which gives accurate baud rates at any ACLK frequency.
- Derives a transmit bit pulse from that tick.
- Derives a receive mid-bit pulse that re-phases on start-bit detection.
- Sits between the UART register block (divisor and enable configuration) and the TX/RX shifters.

## Interface
Parameters:
- CNT_W, 16, width of the integer divisor and the period counter.
- FRAC_W, 4, width of the fractional divisor and the accumulator; 0 < FRAC_W ≤ 8.
- OVS, 16, oversampling ticks per bit; an even number with 4 ≤ OVS ≤ 32.

Ports:
- ACLK  input  1  clock; all logic on the rising edge.
- ARESETn  input  1  reset; synchronous, active-low.
- enable  input  1  generator run; low clears and holds all counters.
- baud_val  input  CNT_W  integer divisor; the base tick period is baud_val+1 cycles.
- baud_frac  input  FRAC_W  fractional divisor, in units of 1/2^FRAC_W cycle.
- rx_resync  input  1  one-cycle strobe from the RX start-bit detector.
- rx_sample_pulse  output  1  oversampling tick, one cycle wide.
- tx_baud_pulse  output  1  TX bit boundary, once per OVS ticks.
- rx_bit_pulse  output  1  RX mid-bit sample strobe.

## Operation
Fractional divider:
- period_cnt counts up from 0.
- The terminal condition is period_cnt ≥ baud_val + ext.
- On terminal: period_cnt ← 0, frac_acc ← frac_acc + baud_frac (FRAC_W bits, wraps), and ext ← carry-out of that add.
- The average tick period is baud_val + 1 + baud_frac/2^FRAC_W cycles.
- Each extended period is exactly one cycle longer than the base period.
- The comparison is ≥ rather than ==. If baud_val is lowered below the current count, the terminal fires on the next cycle and there is no counter run-away.
- baud_val = 0 with baud_frac = 0 gives a tick every cycle.

TX pulse:
- tx_cnt (0..OVS-1) advances on each tick and wraps to 0.
- tx_baud_pulse is asserted on the tick where tx_cnt = OVS-1.

RX pulse:
- rx_phase (0..OVS-1) advances on each tick and wraps.
- rx_bit_pulse is asserted on the tick where rx_phase = OVS/2-1, i.e. half a bit after resync, then every OVS ticks.
- rx_resync sets rx_phase ← 0. If rx_resync coincides with a tick, resync wins: the tick still appears on rx_sample_pulse but does not advance rx_phase, and rx_bit_pulse is suppressed.
- rx_resync does not disturb period_cnt, frac_acc or tx_cnt, so TX framing is never perturbed by RX activity.

Enable:
- enable low clears period_cnt, frac_acc, ext, tx_cnt and rx_phase, and forces all outputs to 0.
- While enable is low, rx_resync is ignored.

Configuration changes:
- baud_val and baud_frac may change at any time.
- The new values take effect at the next terminal comparison; no glitch pulses result.

## Timing
- All outputs are registered.
- Reset value of every output and every counter is 0.
- Startup latency: with enable sampled high at edge E0, the first rx_sample_pulse is high in the cycle following edge E0+baud_val+1.
- Pulses repeat every baud_val+1 (or baud_val+2) cycles.
- Every output is exactly one ACLK cycle wide.
- tx_baud_pulse and rx_bit_pulse only ever coincide with an rx_sample_pulse.
- Reset mid-operation: ARESETn low at an edge clears all state at that edge. Behaviour after release is identical to a fresh enable.
- enable falling mid-period: outputs are low from the next cycle and the partial period is discarded.

## Structure
- Shared package uart_pkg holds:
  - default constants UART_CNT_W, UART_FRAC_W and UART_OVS;
  - the localparam function giving the counter width for OVS, $clog2(OVS).
- Sub-module uart_frac_div holds period_cnt, frac_acc and ext, and outputs the raw tick.
- The top level holds tx_cnt, rx_phase and the output registers.

## Test plan
- baud_val=3, baud_frac=0, OVS=16:
  - rx_sample_pulse every 4 cycles;
  - tx_baud_pulse every 64 cycles;
  - first tick 4 cycles after enable.
- baud_val=3, baud_frac=8, FRAC_W=4:
  - tick periods alternate 4,5,4,5;
  - 16 ticks in exactly 72 cycles;
  - tx_baud_pulse spacing of 72 cycles.
- rx_resync after 5 ticks, then with rx_resync coincident with a tick (OVS=16, baud_val=3):
  - for the post-tick-5 resync, rx_bit_pulse on the 8th tick after resync, then every 16 ticks;
  - tx_baud_pulse cadence unchanged;
  - for the coincident case, that tick is not counted and there is no rx_bit_pulse on it.
- baud_val lowered from 100 to 2 while period_cnt=50:
  - tick on the next cycle;
  - then every 3 cycles;
  - no missing or double pulse.
- enable dropped and ARESETn asserted mid-period:
  - outputs 0 the next cycle;
  - after re-enable, first tick exactly baud_val+1 cycles later;
  - tx_cnt and rx_phase restart from 0.
- baud_val=0, baud_frac=0:
  - rx_sample_pulse high every cycle;
  - tx_baud_pulse every OVS cycles.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared defaults and helpers for the UART baud generator
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_CNT_W  = 16;
    localparam int UART_FRAC_W = 4;
    localparam int UART_OVS    = 16;

    function automatic int ovs_cnt_w(input int ovs);
        return $clog2(ovs);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_frac_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_frac_div : integer + fractional period divider producing a raw tick
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_frac_div
    import uart_pkg::*;
#(
    parameter int CNT_W  = UART_CNT_W,
    parameter int FRAC_W = UART_FRAC_W
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              i_enable,
    input  logic [CNT_W-1:0]  i_baud_val,
    input  logic [FRAC_W-1:0] i_baud_frac,
    output logic              o_tick
);

    logic [CNT_W-1:0]  r_period_cnt;
    logic [FRAC_W-1:0] r_frac_acc;
    logic              r_ext;
    logic              r_tick;

    logic [CNT_W:0]    w_limit;
    logic [FRAC_W:0]   w_frac_sum;
    logic              w_terminal;

    assign w_limit    = {1'b0, i_baud_val} + {{CNT_W{1'b0}}, r_ext};
    assign w_frac_sum = {1'b0, r_frac_acc} + {1'b0, i_baud_frac};
    // All-ones guard keeps a maximal divisor with a pending extension from wrapping the counter.
    assign w_terminal = ({1'b0, r_period_cnt} >= w_limit) || (&r_period_cnt);

    always_ff @(posedge ACLK) begin
        if (!ARESETn || !i_enable) begin
            r_period_cnt <= '0;
            r_frac_acc   <= '0;
            r_ext        <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            r_tick <= w_terminal;
            if (w_terminal) begin
                r_period_cnt <= '0;
                r_frac_acc   <= w_frac_sum[FRAC_W-1:0];
                r_ext        <= w_frac_sum[FRAC_W];
            end else begin
                r_period_cnt <= r_period_cnt + 1'b1;
            end
        end
    end

    assign o_tick = r_tick;

endmodule : uart_frac_div
`default_nettype wire

// File: rtl/uart_baud_frac_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_baud_frac_gen : oversampling tick, TX bit pulse and re-phasable RX pulse
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_baud_frac_gen
    import uart_pkg::*;
#(
    parameter int CNT_W  = UART_CNT_W,
    parameter int FRAC_W = UART_FRAC_W,
    parameter int OVS    = UART_OVS
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              enable,
    input  logic [CNT_W-1:0]  baud_val,
    input  logic [FRAC_W-1:0] baud_frac,
    input  logic              rx_resync,
    output logic              rx_sample_pulse,
    output logic              tx_baud_pulse,
    output logic              rx_bit_pulse
);

    localparam int                c_PH_W    = ovs_cnt_w(OVS);
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(OVS - 1);
    localparam logic [c_PH_W-1:0] c_PH_MID  = c_PH_W'(OVS / 2 - 1);

    logic              w_tick;
    logic [c_PH_W-1:0] r_tx_cnt;
    logic [c_PH_W-1:0] r_rx_phase;
    logic              r_sample;
    logic              r_tx_pulse;
    logic              r_rx_pulse;

    uart_frac_div #(
        .CNT_W  (CNT_W),
        .FRAC_W (FRAC_W)
    ) u_frac_div (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .i_enable    (enable),
        .i_baud_val  (baud_val),
        .i_baud_frac (baud_frac),
        .o_tick      (w_tick)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETn || !enable) begin
            r_tx_cnt   <= '0;
            r_rx_phase <= '0;
            r_sample   <= 1'b0;
            r_tx_pulse <= 1'b0;
            r_rx_pulse <= 1'b0;
        end else begin
            r_sample   <= w_tick;
            r_tx_pulse <= w_tick && (r_tx_cnt == c_PH_LAST);
            if (w_tick) begin
                r_tx_cnt <= (r_tx_cnt == c_PH_LAST) ? '0 : r_tx_cnt + 1'b1;
            end
            // A resync coinciding with a tick swallows that tick for the RX phase only.
            r_rx_pulse <= w_tick && !rx_resync && (r_rx_phase == c_PH_MID);
            if (rx_resync) begin
                r_rx_phase <= '0;
            end else if (w_tick) begin
                r_rx_phase <= (r_rx_phase == c_PH_LAST) ? '0 : r_rx_phase + 1'b1;
            end
        end
    end

    assign rx_sample_pulse = r_sample;
    assign tx_baud_pulse   = r_tx_pulse;
    assign rx_bit_pulse    = r_rx_pulse;

endmodule : uart_baud_frac_gen
`default_nettype wire
